// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory load/store path.
package mem_pkg;

    // Access size encoding as carried on req_size
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_ILL  = 2'd3;

    // Extension op, same encoding as the immediate extender
    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    typedef enum logic [1:0] {
        MAU_IDLE   = 2'd0,
        MAU_REQ    = 2'd1,
        MAU_WAIT_R = 2'd2,
        MAU_RESP   = 2'd3
    } mau_state_e;

    // True when the size is illegal or the address is not naturally aligned
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = off[0];
            SIZE_WORD: err = |off;
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/ld_ext.sv
// Load lane select plus zero/sign extension to 32 bits (purely combinational).
module ld_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        ext,
    output logic [31:0] data
);

    logic [3:0][7:0] lanes;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            fill;

    assign lanes = rdata;

    // Pick the addressed lane(s) and extend per the ext op
    always_comb begin
        byte_v = lanes[addr];
        half_v = addr[1] ? rdata[31:16] : rdata[15:0];
        fill   = 1'b0;
        data   = rdata;
        case (size)
            SIZE_BYTE: begin
                fill = (ext == EXT_SIGN) & byte_v[7];
                data = {{24{fill}}, byte_v};
            end
            SIZE_HALF: begin
                fill = (ext == EXT_SIGN) & half_v[15];
                data = {{16{fill}}, half_v};
            end
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment unit between the MEM stage and a word-addressed,
// variable-latency data memory. Stores are lane-replicated with byte
// enables; loads are lane-selected and extended by ld_ext.
module mem_align_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    mau_state_e  state, state_nxt;

    logic        acc_err;
    logic        accept;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    // Request fields needed after acceptance
    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [1:0]  off_q;

    assign acc_err = access_err(req_size, req_addr[1:0]);
    assign accept  = (state == MAU_IDLE) & req_valid;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= MAU_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        mem_valid = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            MAU_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = acc_err ? MAU_RESP : MAU_REQ;
            end
            MAU_REQ: begin
                mem_valid = 1'b1;
                // rvalid is deliberately not looked at here
                if (mem_ready) state_nxt = we_q ? MAU_RESP : MAU_WAIT_R;
            end
            MAU_WAIT_R: begin
                if (mem_rvalid) state_nxt = MAU_RESP;
            end
            MAU_RESP: begin
                rsp_valid = 1'b1;
                state_nxt = MAU_IDLE;
            end
            default: state_nxt = MAU_IDLE;
        endcase
    end

    // Store lane steering; loads always fetch the full word with no data
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'd0;
        if (req_we) begin
            case (req_size)
                SIZE_BYTE: begin
                    st_be    = 4'b0001 << req_addr[1:0];
                    st_wdata = {4{req_wdata[7:0]}};
                end
                SIZE_HALF: begin
                    st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                    st_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = req_wdata;
                end
            endcase
        end
    end

    ld_ext u_ld_ext (
        .rdata (mem_rdata),
        .addr  (off_q),
        .size  (size_q),
        .ext   (sgn_q),
        .data  (ld_data)
    );

    // Latch the request on acceptance; capture load data on rvalid
    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q      <= 1'b0;
            size_q    <= SIZE_BYTE;
            sgn_q     <= EXT_ZERO;
            off_q     <= 2'd0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_wdata <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q      <= req_we;
                size_q    <= req_size;
                sgn_q     <= req_signed;
                off_q     <= req_addr[1:0];
                rsp_err   <= acc_err;
                rsp_rdata <= '0;
                // Faulting accesses never reach memory, so leave the bus regs alone
                if (!acc_err) begin
                    mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_we    <= req_we;
                    mem_be    <= st_be;
                    mem_wdata <= st_wdata;
                end
            end
            if (state == MAU_WAIT_R && mem_rvalid) rsp_rdata <= ld_data;
        end
    end

endmodule

// File: tb/tb_mem_align_unit.sv
// Randomized self-checking bench for mem_align_unit with a behavioural model.
module tb_mem_align_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_align_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (size == 2'd1) return (addr % 2) != 0;
        if (size == 2'd2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        if (size == 2'd2) return rdata;
        if (size == 2'd1) begin
            v = (rdata >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
            if (sgn && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = (rdata >> (8 * (addr % 4))) & 32'hFF;
            if (sgn && v >= 32'h80) v = v - 32'h100;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_be(input logic we, input logic [1:0] size, input logic [31:0] addr);
        if (!we || size == 2'd2) return 32'd15;
        if (size == 2'd1) return 32'd3 << (addr % 4);
        return 32'd1 << (addr % 4);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic we, input logic [1:0] size, input logic [31:0] wd);
        if (!we) return 32'd0;
        if (size == 2'd0) return (wd & 32'hFF) * 32'h01010101;
        if (size == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    // One full access: rd = REQ cycles before mem_ready, rv = WAIT_R cycles until rvalid (>=1).
    // hold keeps a (changing) req_valid asserted while busy, which must be ignored.
    task automatic run_access(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int rd, input int rv, input bit hold);
        bit          err, done, saw_mem;
        int          n, hs, req_cyc, exp_lat;
        logic [31:0] exp_rd;
        err     = ref_err(size, addr);
        exp_rd  = (err || we) ? 32'd0 : ref_load(rdata, addr, size, sgn);
        exp_lat = err ? 1 : (we ? 2 + rd : 2 + rd + rv);

        @(negedge clk);
        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);

        n = 0; done = 0; saw_mem = 0; hs = -1; req_cyc = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            req_valid = hold;
            if (hold) begin
                req_we = $urandom; req_size = $urandom; req_signed = $urandom;
                req_addr = $urandom; req_wdata = $urandom;
            end
            if (rsp_valid) begin
                req_valid = 1'b0;
                chk("latency", n, exp_lat);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, err});
                chk("rsp_rdata", rsp_rdata, exp_rd);
                done = 1;
            end else begin
                chk("busy", {31'd0, busy}, 32'd1);
                chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
                if (mem_valid) begin
                    saw_mem = 1;
                    chk("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
                    chk("mem_we", {31'd0, mem_we}, {31'd0, we});
                    chk("mem_be", {28'd0, mem_be}, ref_be(we, size, addr));
                    chk("mem_wdata", mem_wdata, ref_wdata(we, size, wdata));
                    if (req_cyc == rd) begin
                        mem_ready = 1'b1;
                        hs = n;
                    end
                    req_cyc++;
                end else if (hs >= 0 && !we && n - hs == rv) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                end
            end
        end
        if (!done) chk("rsp_timeout", 32'd0, 32'd1);
        chk("mem_access_issued", {31'd0, saw_mem}, {31'd0, !err});
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("req_ready_after", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_busy"},      {31'd0, busy}, 32'd0);
        chk({tag, "_mem_valid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, "_mem_addr"},  mem_addr, 32'd0);
        chk({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_be"},    {28'd0, mem_be}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"},   {31'd0, rsp_err}, 32'd0);
    endtask

    initial begin
        logic        we, sgn;
        logic [1:0]  size;
        logic [31:0] addr;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;

        // Directed cases
        run_access(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AB, 32'd0, 0, 1, 0);
        run_access(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 32'h8001_7FFF, 0, 1, 0);
        run_access(1'b0, 2'd1, 1'b0, 32'h22, 32'd0, 32'h8001_7FFF, 0, 1, 0);
        run_access(1'b0, 2'd0, 1'b0, 32'h05, 32'd0, 32'h1122_3344, 0, 1, 0);
        run_access(1'b0, 2'd0, 1'b1, 32'h05, 32'd0, 32'h0000_F000, 0, 1, 0);
        run_access(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, 32'h1234_5678, 0, 1, 0);
        run_access(1'b0, 2'd3, 1'b0, 32'h08, 32'd0, 32'h1234_5678, 0, 1, 0);
        run_access(1'b1, 2'd1, 1'b0, 32'h1E, 32'hCAFE_BEEF, 32'd0, 5, 1, 1);
        run_access(1'b0, 2'd2, 1'b0, 32'h30, 32'd0, 32'hDEAD_BEEF, 5, 3, 1);

        // Reset in WAIT_R; a late rvalid must be ignored
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_req_mem_valid", {31'd0, mem_valid}, 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("abort_wait_busy", {31'd0, busy}, 32'd1);
        chk("abort_wait_mem_valid", {31'd0, mem_valid}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs("abort");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_rvalid = 1'b1; mem_rdata = $urandom;
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("abort_idle", {31'd0, req_ready}, 32'd1);
        end
        mem_rvalid = 1'b0;

        // Randomized accesses
        for (int i = 0; i < 150; i++) begin
            we   = $urandom;
            size = $urandom;
            sgn  = $urandom;
            addr = $urandom;
            if (size != 2'd3 && $urandom_range(0, 3) != 0)
                addr = addr & ~((32'd1 << size) - 32'd1);
            run_access(we, size, sgn, addr, $urandom, $urandom,
                       $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
